// File: rtl/mio_bus_responder.sv
// MIO bus target: word RAM, GPIO (LEDs/switches) and a free-running cycle counter.
// Ports: clk/reset, CPU_MIO/mem_w/Addr_in/Data_in request, Data_out/MIO_ready response,
//        sw_in switches, led_out LED register, bus_err sticky unmapped-access flag.
module mio_bus_responder #(
    parameter int RAM_AW      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        ACK
    } state_t;

    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [3:0]          region_q;
    logic [RAM_AW-1:0]   idx_q;
    logic                wr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         cnt_q;
    logic [31:0]         rd_data;
    logic                commit;
    logic                sel_ram, sel_gpio, sel_cnt, sel_none;

    logic [31:0] ram [1<<RAM_AW];

    // Only the region nibble and the word index are ever decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr_in[27:RAM_AW+2], Addr_in[1:0]};

    assign commit   = (state_q == RESP);
    assign sel_ram  = (region_q == 4'h0);
    assign sel_gpio = (region_q == 4'hE);
    assign sel_cnt  = (region_q == 4'hF);
    assign sel_none = !(sel_ram || sel_gpio || sel_cnt);

    // WAIT lasts WAIT_CYCLES+1 cycles, giving request-to-ready of 2+WAIT_CYCLES edges.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (CPU_MIO) begin
                    wcnt_d  = WC;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) state_d = RESP;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            RESP: state_d = ACK;
            ACK: begin
                if (!CPU_MIO) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // GPIO offset [3:2] is the low two bits of the latched word index.
    always_comb begin
        rd_data = 32'h0;
        unique case (1'b1)
            sel_ram: rd_data = ram[idx_q];
            sel_gpio: begin
                if (idx_q[1:0] == 2'd0)      rd_data = {16'h0, led_out};
                else if (idx_q[1:0] == 2'd1) rd_data = {16'h0, sw_in};
            end
            sel_cnt:  rd_data = cnt_q;
            sel_none: rd_data = 32'h0;
            default:  rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && wr_q && sel_ram) begin
            ram[idx_q] <= wdata_q;
        end
    end

    // A bus load takes priority over the free-running increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'h0;
        end else if (commit && wr_q && sel_cnt) begin
            cnt_q <= wdata_q;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wcnt_q    <= 4'd0;
            region_q  <= 4'h0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= 32'h0;
            Data_out  <= 32'h0;
            MIO_ready <= 1'b0;
            led_out   <= 16'h0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            MIO_ready <= (state_d == ACK);
            if (state_q == IDLE && CPU_MIO) begin
                region_q <= Addr_in[31:28];
                idx_q    <= Addr_in[RAM_AW+1:2];
                wr_q     <= mem_w;
                wdata_q  <= Data_in;
            end
            if (commit) begin
                if (sel_none) bus_err <= 1'b1;
                if (wr_q) begin
                    if (sel_gpio && idx_q[1:0] == 2'd0) led_out <= wdata_q[15:0];
                end else begin
                    Data_out <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: directed scenarios plus random traffic
// checked against an address-map level reference model.
module tb_mio_bus_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CPU_MIO = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] Addr_in = 32'h0;
    logic [31:0] Data_in = 32'h0;
    logic [31:0] Data_out;
    logic        MIO_ready;
    logic [15:0] sw_in = 16'h0;
    logic [15:0] led_out;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mram [1024];
    bit          mvalid [1024];
    logic [15:0] mled;
    bit          merr;
    logic [31:0] cbase;
    int          cedge;

    mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_in(Addr_in), .Data_in(Data_in), .Data_out(Data_out),
        .MIO_ready(MIO_ready), .sw_in(sw_in), .led_out(led_out),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        CPU_MIO = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cedge = cyc;
        cbase = 32'h0;
        mled = 16'h0;
        merr = 0;
        chk("rst_ready", {31'h0, MIO_ready}, 32'h0);
        chk("rst_data", Data_out, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_err", {31'h0, bus_err}, 32'h0);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output int e);
        int n;
        bit got;
        @(negedge clk);
        CPU_MIO = 1'b1;
        mem_w = w;
        Addr_in = a;
        Data_in = d;
        n = cyc + 1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (MIO_ready) got = 1;
            // latched copy must be used, so scramble the bus
            Addr_in = $urandom;
            Data_in = $urandom;
            mem_w = 1'($urandom);
        end
        chk("ready_seen", {31'h0, got}, 32'h1);
        e = cyc;
        rd = Data_out;
        chk("latency", 32'(e - n), 32'(2 + W));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_ready", {31'h0, MIO_ready}, 32'h1);
            chk("hold_data", Data_out, rd);
        end
        CPU_MIO = 1'b0;
        @(negedge clk);
        chk("ready_drop", {31'h0, MIO_ready}, 32'h0);
    endtask

    task automatic op(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int hold);
        logic [31:0] rd, exp;
        logic [9:0]  ix;
        int e;
        xfer(w, a, d, hold, rd, e);
        exp = 32'h0;
        ix = a[11:2];
        case (a[31:28])
            4'h0: begin
                exp = mram[ix];
                if (w) begin
                    mram[ix] = d;
                    mvalid[ix] = 1;
                end
            end
            4'hE: begin
                if (a[3:2] == 2'd0) begin
                    exp = {16'h0, mled};
                    if (w) mled = d[15:0];
                end else if (a[3:2] == 2'd1) begin
                    exp = {16'h0, sw_in};
                end
            end
            4'hF: begin
                exp = cbase + 32'(e - cedge - 1);
                if (w) begin
                    cbase = d;
                    cedge = e;
                end
            end
            default: merr = 1;
        endcase
        if (!w) chk($sformatf("rd_%h", a), rd, exp);
        chk("led", {16'h0, led_out}, {16'h0, mled});
        chk("bus_err", {31'h0, bus_err}, {31'h0, merr});
    endtask

    initial begin
        logic [31:0] a, d;
        logic [9:0]  ix;
        int n;
        bit got;
        for (int i = 0; i < 1024; i++) mvalid[i] = 0;
        do_reset();

        // counter starts from zero at reset
        op(0, 32'hF000_0000, 0, 0);
        // basic RAM write/read
        op(1, 32'h0000_0010, 32'h1234_5678, 0);
        op(0, 32'h0000_0010, 0, 0);
        // aliasing above the RAM index
        op(1, 32'h0000_1010, 32'hA5A5_A5A5, 0);
        op(0, 32'h0000_0010, 0, 0);
        // GPIO
        op(1, 32'hE000_0000, 32'hFFFF_00C3, 0);
        op(0, 32'hE000_0000, 0, 0);
        sw_in = 16'hBEEF;
        op(0, 32'hE000_0004, 0, 0);
        op(0, 32'hE000_0008, 0, 0);
        op(1, 32'hE000_0004, 32'h1234_5678, 0);
        // counter load and wrap
        op(1, 32'hF000_0000, 32'hFFFF_FFFE, 0);
        op(0, 32'hF000_0000, 0, 0);
        op(0, 32'hF000_0000, 0, 1);
        // long hold must commit the load once
        op(1, 32'hF000_0000, 32'h0000_1000, 5);
        op(0, 32'hF000_0000, 0, 0);
        op(1, 32'h0000_0030, 32'h0BAD_F00D, 5);
        op(0, 32'h0000_0030, 0, 5);
        // unmapped
        op(0, 32'h5000_0000, 0, 0);
        op(1, 32'h0000_0020, 32'h0000_0099, 0);
        op(0, 32'h0000_0020, 0, 0);

        // reset during WAIT of a RAM write
        @(negedge clk);
        CPU_MIO = 1'b1;
        mem_w = 1'b1;
        Addr_in = 32'h0000_0020;
        Data_in = 32'h0000_0011;
        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_ready", {31'h0, MIO_ready}, 32'h0);
        end
        op(0, 32'h0000_0020, 0, 0);
        op(0, 32'hF000_0000, 0, 0);

        // request dropped during WAIT still completes
        @(negedge clk);
        CPU_MIO = 1'b1;
        mem_w = 1'b0;
        Addr_in = 32'h0000_0010;
        n = cyc + 1;
        @(negedge clk);
        CPU_MIO = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (MIO_ready) got = 1;
        end
        chk("early_seen", {31'h0, got}, 32'h1);
        chk("early_lat", 32'(cyc - n), 32'(2 + W));
        chk("early_data", Data_out, mram[4]);
        @(negedge clk);
        chk("early_exit", {31'h0, MIO_ready}, 32'h0);

        // random traffic
        for (int t = 0; t < 50; t++) begin
            int k;
            logic w;
            k = $urandom_range(0, 9);
            w = 1'($urandom);
            d = $urandom;
            sw_in = 16'($urandom);
            if (k < 4) begin
                ix = 10'h40 + 10'($urandom_range(0, 15));
                if (!mvalid[ix]) w = 1;
                a = {4'h0, 16'($urandom), ix, 2'($urandom)};
            end else if (k < 6) begin
                a = {4'hE, 28'($urandom)};
            end else if (k < 8) begin
                a = {4'hF, 28'($urandom)};
            end else begin
                a = {4'($urandom_range(1, 13)), 28'($urandom)};
            end
            op(w, a, d, $urandom_range(0, 2));
        end

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
